rv_multicycle_ctrl: RTL and testbench
=====================================

# rv_multicycle_ctrl

Multi-cycle control FSM that sequences the RV32I `data_path`. It latches each fetched instruction's opcode, func3 and func7[5], then steps the datapath through fetch, decode, execute, memory and writeback. In each state it drives the existing control bundle (`reg_write`, `alu_src`, `mem_write`, `alu_ctrl`, `mem_to_reg`, `branch`, `func3`) plus PC and IR strobes. It sits beside `data_path` at core top level and replaces bench-driven control.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-high reset; the `_n` suffix is kept for port-name compatibility with `data_path`.
- `instr`  in  32  instruction word from instruction memory; sampled only in FETCH.
- `mem_ready`  in  1  data-memory completion for the current load/store.
- `ir_write`  out  1  IR load strobe.
- `pc_write`  out  1  PC update strobe; datapath takes the branch target when `branch` is high and its compare is true.
- `reg_write`, `alu_src`, `mem_write`, `mem_to_reg`, `branch`  out  1 each  datapath controls.
- `alu_ctrl`  out  4  ALU operation.
- `func3`  out  3  latched func3, used for memory width and branch sense.
- `instr_done`  out  1  one-cycle pulse in the last cycle of each instruction.
- `illegal_instr`  out  1  sticky trap flag (see Configuration).

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset state: IDLE. IDLE always goes to FETCH on the next cycle.
- FETCH: `ir_write`=1; latch `instr[6:0]`, `instr[14:12]`, `instr[30]`; go to DECODE.
- DECODE: classify opcode.
  - 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH) go to EXEC.
  - Any other opcode follows Configuration.
- EXEC:
  - R and I-ALU go to WB.
  - LOAD and STORE go to MEM.
  - BRANCH: `branch`=1, `pc_write`=1, `instr_done`=1; go to FETCH.
- MEM:
  - STORE holds `mem_write`=1 every cycle it stays in MEM.
  - Stay in MEM while `mem_ready`=0.
  - On `mem_ready`=1: STORE asserts `pc_write`=1 and `instr_done`=1, then goes to FETCH; LOAD goes to WB.
- WB: `reg_write`=1, `pc_write`=1, `instr_done`=1; `mem_to_reg`=1 for LOAD only; go to FETCH.
- `alu_src`=1 for I-ALU, LOAD and STORE in EXEC/MEM/WB; otherwise 0.
- `alu_ctrl` encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu.
- `alu_ctrl` by class:
  - R type: decoded from func3, with func7[5] selecting sub/sra.
  - I-ALU: decoded from func3; func7[5] is honoured only when func3=101 (srai).
  - LOAD and STORE: add.
  - BRANCH: func3 00x gives sub; 10x gives slt; 11x gives sltu.
- All outputs are functions of the state register and latched fields only; there is no combinational path from `instr` or `mem_ready` to any output except the MEM exit.

## Timing
- Reset values: every output 0, `illegal_instr` 0, state IDLE.
- While `reset_n`=1, outputs stay 0. A reset asserted mid-instruction (including mid-MEM) returns the FSM to IDLE on the next edge. No `pc_write`, `reg_write` or `instr_done` is issued for the aborted instruction, and `mem_write` drops on that edge.
- Latency in cycles, from FETCH through the cycle that carries `instr_done`:
  - BRANCH: 3.
  - R, I-ALU: 4.
  - STORE: 4 + w, where w = cycles with `mem_ready`=0 in MEM.
  - LOAD: 5 + w.
- `mem_ready` is ignored outside MEM. A `mem_ready` that is already high on MEM entry completes the access in one cycle.
- `pc_write` and `reg_write` are never high in the same cycle as `ir_write`.

## Configuration
- `CTRL_TRAP_EN` defined:
  - An unsupported opcode, or R-type with func7[5]=1 and func3 not in {000, 101}, takes DECODE to TRAP.
  - TRAP sets `illegal_instr`=1, drives all other outputs 0, and stays in TRAP until reset.
- `CTRL_TRAP_EN` undefined:
  - Such instructions execute as a NOP: DECODE asserts `pc_write`=1 and `instr_done`=1, then goes to FETCH (2 cycles).
  - No TRAP state exists; `illegal_instr` is tied to 0.

## Test plan
- Reset for 3 cycles, then `instr`=0x00A00293 (addi t0,x0,10). Required: outputs 0 during reset; IDLE then FETCH with `ir_write`; in WB `reg_write`=1, `alu_src`=1, `alu_ctrl`=0000; `instr_done` in cycle 4 after FETCH.
- `instr`=0x40628333 (sub). Required: `alu_ctrl`=0001 and `alu_src`=0 in EXEC and WB.
- Load 0x0002A303 with `mem_ready` low for 3 cycles. Required: MEM lasts 4 cycles; WB has `mem_to_reg`=1 and `reg_write`=1; total latency 8.
- Store 0x0062A023 with `mem_ready` already high. Required: `mem_write`=1 for exactly 1 cycle, `reg_write` never asserted, `instr_done` in cycle 4.
- Branch 0x00628463 (beq). Required: EXEC has `branch`=1, `pc_write`=1, `alu_ctrl`=0001; latency 3. Repeat with bltu 0x0062E463: `alu_ctrl`=1001.
- Opcode 0x0000007F, then reset asserted mid-MEM of a load.
  - With `CTRL_TRAP_EN`: `illegal_instr` goes to 1 and holds until reset.
  - Without it: 2-cycle NOP with `pc_write`.
  - Reset mid-MEM: IDLE next edge, no `reg_write`.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle control FSM that sequences the RV32I data_path.
// Latches opcode/func3/func7[5] in FETCH, then steps through DECODE, EXEC,
// MEM and WB, driving the datapath control bundle plus PC/IR strobes.
// Optional feature macro: CTRL_TRAP_EN -- when defined, unsupported
// instructions enter a sticky TRAP state; otherwise they retire as a NOP.
// reset_n is an active-high synchronous reset (name kept for compatibility).
module rv_multicycle_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        alu_src,
    output logic        mem_write,
    output logic [3:0]  alu_ctrl,
    output logic        mem_to_reg,
    output logic        branch,
    output logic [2:0]  func3,
    output logic        instr_done,
    output logic        illegal_instr
);

`ifdef CTRL_TRAP_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;
`endif

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    state_t      state_q;
    state_t      state_d;
    logic [6:0]  opcode_q;
    logic [2:0]  func3_q;
    logic        f7b5_q;

    logic        is_r;
    logic        is_i;
    logic        is_ld;
    logic        is_st;
    logic        is_br;
    logic        r_bad;
    logic        legal;
    logic        uses_imm;
    logic [3:0]  alu_op;

    // Instruction bits this controller never looks at.
    logic        unused_instr;
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    // State register and instruction-field latch (fields captured only in FETCH).
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            func3_q  <= '0;
            f7b5_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH) begin
                opcode_q <= instr[6:0];
                func3_q  <= instr[14:12];
                f7b5_q   <= instr[30];
            end
        end
    end

    // Instruction class from the latched opcode and funct fields.
    always_comb begin
        is_r     = (opcode_q == OP_R);
        is_i     = (opcode_q == OP_I);
        is_ld    = (opcode_q == OP_LOAD);
        is_st    = (opcode_q == OP_STORE);
        is_br    = (opcode_q == OP_BRANCH);
        r_bad    = is_r && f7b5_q && (func3_q != 3'b000) && (func3_q != 3'b101);
        legal    = (is_r && !r_bad) || is_i || is_ld || is_st || is_br;
        uses_imm = is_i || is_ld || is_st;
    end

    // ALU operation for the latched instruction class.
    always_comb begin
        alu_op = ALU_ADD;
        if (is_br) begin
            case (func3_q[2:1])
                2'b10:   alu_op = ALU_SLT;
                2'b11:   alu_op = ALU_SLTU;
                default: alu_op = ALU_SUB;
            endcase
        end else if (is_r || is_i) begin
            case (func3_q)
                3'b000:  alu_op = (is_r && f7b5_q) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = f7b5_q ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

    // Next-state and per-state control outputs; reset forces every output low.
    always_comb begin
        state_d       = state_q;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src       = 1'b0;
        mem_write     = 1'b0;
        alu_ctrl      = ALU_ADD;
        mem_to_reg    = 1'b0;
        branch        = 1'b0;
        func3         = func3_q;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                ir_write = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                if (legal) begin
                    state_d = EXEC;
                end else begin
`ifdef CTRL_TRAP_EN
                    state_d = TRAP;
`else
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH;
`endif
                end
            end
            EXEC: begin
                alu_src  = uses_imm;
                alu_ctrl = alu_op;
                if (is_br) begin
                    branch     = 1'b1;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end else if (is_ld || is_st) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                alu_src   = 1'b1;
                alu_ctrl  = alu_op;
                mem_write = is_st;
                // Only combinational input-to-output path: store retires on mem_ready.
                if (mem_ready) begin
                    if (is_st) begin
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                mem_to_reg = is_ld;
                alu_src    = uses_imm;
                alu_ctrl   = alu_op;
                state_d    = FETCH;
            end
`ifdef CTRL_TRAP_EN
            TRAP: begin
                illegal_instr = 1'b1;
                func3         = '0;
                state_d       = TRAP;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Gating here keeps an aborted instruction from retiring in the reset cycle.
        if (reset_n) begin
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            reg_write     = 1'b0;
            alu_src       = 1'b0;
            mem_write     = 1'b0;
            alu_ctrl      = '0;
            mem_to_reg    = 1'b0;
            branch        = 1'b0;
            func3         = '0;
            instr_done    = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl. A cycle-indexed reference model
// of each instruction class predicts every output in every cycle; randomized
// instruction streams and mem_ready stalls exercise it. Honors CTRL_TRAP_EN.
module tb_rv_multicycle_ctrl;

    logic        clk;
    logic        reset_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        alu_src;
    logic        mem_write;
    logic [3:0]  alu_ctrl;
    logic        mem_to_reg;
    logic        branch;
    logic [2:0]  func3;
    logic        instr_done;
    logic        illegal_instr;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2:0] f3_model = '0;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_BAD = 5;

    rv_multicycle_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .instr         (instr),
        .mem_ready     (mem_ready),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src       (alu_src),
        .mem_write     (mem_write),
        .alu_ctrl      (alu_ctrl),
        .mem_to_reg    (mem_to_reg),
        .branch        (branch),
        .func3         (func3),
        .instr_done    (instr_done),
        .illegal_instr (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int classify(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'b0110011: return (ins[30] && f3 != 3'd0 && f3 != 3'd5) ? K_BAD : K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            default:    return K_BAD;
        endcase
    endfunction

    // add=0 sub=1 and=2 or=3 xor=4 sll=5 srl=6 sra=7 slt=8 sltu=9
    function automatic logic [3:0] ref_alu(input int k, input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        if (k == K_LD || k == K_ST) return 4'd0;
        if (k == K_BR) begin
            if (f3 == 3'd4 || f3 == 3'd5) return 4'd8;
            if (f3 == 3'd6 || f3 == 3'd7) return 4'd9;
            return 4'd1;
        end
        case (f3)
            3'd0: return (k == K_R && ins[30]) ? 4'd1 : 4'd0;
            3'd1: return 4'd5;
            3'd2: return 4'd8;
            3'd3: return 4'd9;
            3'd4: return 4'd4;
            3'd5: return ins[30] ? 4'd7 : 4'd6;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic bit trap_build();
`ifdef CTRL_TRAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Cycle of instr_done counted from FETCH=1; 0 means never retires.
    function automatic int ref_latency(input int k, input int w);
        case (k)
            K_BR:       return 3;
            K_R, K_I:   return 4;
            K_ST:       return 4 + w;
            K_LD:       return 5 + w;
            default:    return trap_build() ? 0 : 2;
        endcase
    endfunction

    function automatic logic [15:0] observed();
        return {ir_write, pc_write, reg_write, alu_src, mem_write, mem_to_reg,
                branch, alu_ctrl, func3, instr_done, illegal_instr};
    endfunction

    // Hold reset for n cycles, then release and check the IDLE cycle.
    task automatic do_reset(input int n);
        logic [15:0] obs;
        reset_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            instr = $urandom;
            mem_ready = 1'($urandom);
            #1;
            obs = observed();
            n_checks++;
            if (obs !== 16'h0) $display("FAIL reset_hold cycle %0d: got %b want %b", i, obs, 16'h0);
            else n_pass++;
        end
        reset_n = 1'b0;
        #1;
        obs = observed();
        n_checks++;
        if (obs !== 16'h0) $display("FAIL reset_idle: got %b want %b", obs, 16'h0);
        else n_pass++;
        f3_model = '0;
    endtask

    // Run one instruction from its FETCH cycle, checking every output each cycle.
    // abort_at>0 asserts reset in that cycle; a trap in a trapping build is
    // observed for three cycles and then cleared the same way.
    task automatic run_instr(input string name, input logic [31:0] ins, input int w,
                             input int abort_at, output int done_cyc,
                             output int memw_cyc, output int regw_cyc);
        int k, lat, total, abort_c, mem_last;
        bit trapping, in_mem;
        logic [3:0] op;
        logic [15:0] exp, obs;
        logic e_ir, e_pc, e_rw, e_src, e_mw, e_m2r, e_br, e_done, e_ill;
        logic [3:0] e_alu;
        logic [2:0] e_f3;

        k        = classify(ins);
        op       = ref_alu(k, ins);
        trapping = trap_build() && (k == K_BAD);
        lat      = ref_latency(k, w);
        mem_last = 4 + w;
        abort_c  = trapping ? 6 : abort_at;
        total    = (abort_c > 0) ? abort_c : lat;
        done_cyc = 0; memw_cyc = 0; regw_cyc = 0;

        for (int c = 1; c <= total; c++) begin
            @(posedge clk); #1;
            if (c == abort_c) begin
                reset_n = 1'b1; mem_ready = 1'b1; instr = $urandom;
                #1;
                obs = observed();
                n_checks++;
                if (obs !== 16'h0) $display("FAIL %s abort cycle %0d: got %b want %b", name, c, obs, 16'h0);
                else n_pass++;
                @(posedge clk); #1;
                reset_n = 1'b0;
                #1;
                obs = observed();
                n_checks++;
                if (obs !== 16'h0) $display("FAIL %s post-abort idle: got %b want %b", name, obs, 16'h0);
                else n_pass++;
                f3_model = '0;
                break;
            end
            in_mem = (k == K_LD || k == K_ST) && !trapping && c >= 4 && c <= mem_last;
            instr = (c == 1) ? ins : $urandom;
            mem_ready = in_mem ? (c == mem_last) : 1'($urandom);
            #1;

            {e_ir, e_pc, e_rw, e_src, e_mw, e_m2r, e_br, e_done, e_ill} = '0;
            e_alu = 4'd0;
            e_f3  = (c == 1) ? f3_model : ins[14:12];
            if (c == 1) begin
                e_ir = 1'b1;
            end else if (c == 2) begin
                if (k == K_BAD && !trapping) begin e_pc = 1'b1; e_done = 1'b1; end
            end else if (trapping) begin
                e_ill = 1'b1; e_f3 = 3'd0;
            end else if (c == 3) begin
                e_src = (k == K_I || k == K_LD || k == K_ST);
                e_alu = op;
                if (k == K_BR) begin e_br = 1'b1; e_pc = 1'b1; e_done = 1'b1; end
            end else if (in_mem) begin
                e_src = 1'b1; e_alu = op; e_mw = (k == K_ST);
                if (k == K_ST && c == mem_last) begin e_pc = 1'b1; e_done = 1'b1; end
            end else begin
                e_rw = 1'b1; e_pc = 1'b1; e_done = 1'b1; e_m2r = (k == K_LD);
                e_src = (k == K_I || k == K_LD); e_alu = op;
            end
            exp = {e_ir, e_pc, e_rw, e_src, e_mw, e_m2r, e_br, e_alu, e_f3, e_done, e_ill};

            obs = observed();
            n_checks++;
            if (obs !== exp) $display("FAIL %s cycle %0d (instr %h): got %b want %b", name, c, ins, obs, exp);
            else n_pass++;
            if (instr_done === 1'b1 && done_cyc == 0) done_cyc = c;
            if (mem_write === 1'b1) memw_cyc++;
            if (reg_write === 1'b1) regw_cyc++;
            if (c == 1) f3_model = ins[14:12];
        end
    endtask

    task automatic test_reset();
        do_reset(3);
    endtask

    task automatic test_addi();
        int d, m, r;
        run_instr("addi", 32'h00A00293, 0, 0, d, m, r);
        n_checks++;
        if (d != 4 || r != 1) $display("FAIL addi_latency: got done=%0d regw=%0d want done=4 regw=1", d, r);
        else n_pass++;
    endtask

    task automatic test_sub();
        int d, m, r;
        run_instr("sub", 32'h40628333, 0, 0, d, m, r);
        n_checks++;
        if (d != 4) $display("FAIL sub_latency: got %0d want 4", d);
        else n_pass++;
    endtask

    task automatic test_load();
        int d, m, r;
        run_instr("load_w3", 32'h0002A303, 3, 0, d, m, r);
        n_checks++;
        if (d != 8 || r != 1 || m != 0) $display("FAIL load_latency: got done=%0d regw=%0d memw=%0d want 8/1/0", d, r, m);
        else n_pass++;
    endtask

    task automatic test_store();
        int d, m, r;
        run_instr("store_w0", 32'h0062A023, 0, 0, d, m, r);
        n_checks++;
        if (d != 4 || m != 1 || r != 0) $display("FAIL store_latency: got done=%0d memw=%0d regw=%0d want 4/1/0", d, m, r);
        else n_pass++;
    endtask

    task automatic test_branch();
        int d, m, r;
        run_instr("beq", 32'h00628463, 0, 0, d, m, r);
        n_checks++;
        if (d != 3) $display("FAIL beq_latency: got %0d want 3", d);
        else n_pass++;
        run_instr("bltu", 32'h0062E463, 0, 0, d, m, r);
        n_checks++;
        if (d != 3) $display("FAIL bltu_latency: got %0d want 3", d);
        else n_pass++;
    endtask

    task automatic test_illegal();
        int d, m, r;
        run_instr("illegal_7f", 32'h0000007F, 0, 0, d, m, r);
        n_checks++;
        if (d != (trap_build() ? 0 : 2)) $display("FAIL illegal_latency: got %0d want %0d", d, trap_build() ? 0 : 2);
        else n_pass++;
    endtask

    task automatic test_reset_mid_mem();
        int d, m, r;
        run_instr("load_abort", 32'h0002A303, 5, 5, d, m, r);
        n_checks++;
        if (d != 0 || r != 0) $display("FAIL load_abort: got done=%0d regw=%0d want 0/0", d, r);
        else n_pass++;
        run_instr("store_abort", 32'h0062A023, 4, 6, d, m, r);
        n_checks++;
        if (d != 0 || m != 2) $display("FAIL store_abort: got done=%0d memw=%0d want 0/2", d, m);
        else n_pass++;
        run_instr("addi_after_abort", 32'h00A00293, 0, 0, d, m, r);
        n_checks++;
        if (d != 4) $display("FAIL recovery_latency: got %0d want 4", d);
        else n_pass++;
    endtask

    task automatic test_back_to_back_random();
        logic [6:0] ops [6];
        logic [31:0] ins;
        int d, m, r, w, exp_d;
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1110111;
        for (int i = 0; i < 60; i++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 5)];
            w = $urandom_range(0, 3);
            exp_d = ref_latency(classify(ins), w);
            run_instr("random", ins, w, 0, d, m, r);
            n_checks++;
            if (d != exp_d) $display("FAIL random_latency (instr %h w=%0d): got %0d want %0d", ins, w, d, exp_d);
            else n_pass++;
        end
    endtask

    initial begin
        reset_n   = 1'b1;
        instr     = '0;
        mem_ready = 1'b0;
        test_reset();
        test_addi();
        test_sub();
        test_load();
        test_store();
        test_branch();
        test_illegal();
        test_reset_mid_mem();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
